// File: rtl/dac_controller.sv
// -----------------------------------------------------------------------------
// dac_controller
//   SPI master for a single DAC that uses 24-bit frames. The control loop or the
//   CPU register bank uses it to write the DAC value, read the DAC value back,
//   write the DAC control register, and read the control register back.
//   A readback needs two frames: a command frame, then a NOP frame that clocks
//   the response out of the DAC.
//
// Ports
//   clk       system clock
//   rst_L     asynchronous active-low reset
//   arm       level request; an op starts when arm is high while idle
//   op        00 wr DAC, 01 rd DAC, 10 wr ctrl, 11 rd ctrl (latched at start)
//   data_in   write payload, latched at start (wr DAC uses [DATA_WID-1:0])
//   busy      transaction in progress
//   finished  op complete; held until arm goes low
//   data_out  readback payload (DAC value zero-extended)
//   rd_err    readback header mismatch on the last read
//   sck       SPI clock, idles at POLARITY
//   mosi      SPI data to the DAC
//   miso      SPI data from the DAC
//   ss_L      SPI select, active low
// -----------------------------------------------------------------------------
module dac_controller #(
  parameter int POLARITY  = 0,
  parameter int PHASE     = 1,
  parameter int WID       = 24,
  parameter int DATA_WID  = 20,
  parameter int HALF_WAIT = 2,
  parameter int SS_WAIT   = 2,
  parameter int TIMER_WID = 8
) (
  input  logic           clk,
  input  logic           rst_L,
  input  logic           arm,
  input  logic [1:0]     op,
  input  logic [WID-5:0] data_in,
  output logic           busy,
  output logic           finished,
  output logic [WID-5:0] data_out,
  output logic           rd_err,
  output logic           sck,
  output logic           mosi,
  input  logic           miso,
  output logic           ss_L
);

  localparam int PAY_WID = WID - 4;
  localparam int CNT_WID = $clog2(2 * WID);
  localparam logic [CNT_WID-1:0]   LAST_EDGE = CNT_WID'(2 * WID - 1);
  localparam logic [TIMER_WID-1:0] HALF_LAST = TIMER_WID'(HALF_WAIT - 1);
  localparam logic [TIMER_WID-1:0] SS_LAST   = TIMER_WID'(SS_WAIT - 1);
  localparam logic                 SCK_IDLE  = 1'(POLARITY);
  localparam logic [PAY_WID-1:0]   DAC_MASK  = ~({PAY_WID{1'b1}} << DATA_WID);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Header nibble for each op: bit3 = read, bit1/bit0 select ctrl/DAC.
  // Reads send 1001/1010, writes 0001/0010; the DAC echoes the read header.
  function automatic logic [3:0] op_header(input logic [1:0] o);
    return {o[0], 1'b0, o[1], ~o[1]};
  endfunction

  // Command word of the first frame of an op.
  function automatic logic [WID-1:0] cmd_word(input logic [1:0] o, input logic [PAY_WID-1:0] d);
    logic [PAY_WID-1:0] payload;
    if (o[0]) begin
      payload = {PAY_WID{1'b0}};
    end else if (o[1]) begin
      payload = d;
    end else begin
      payload = d & DAC_MASK;
    end
    return {op_header(o), payload};
  endfunction

  state_t               state_r, state_s;
  logic [TIMER_WID-1:0] timer_r, timer_s;
  logic [CNT_WID-1:0]   edge_r, edge_s;
  logic [1:0]           op_r, op_s;
  logic                 frame_r, frame_s;
  logic [WID-1:0]       tx_r, tx_s;
  logic [WID-1:0]       rx_r, rx_s;
  logic                 sck_r, sck_s;
  logic                 mosi_r, mosi_s;
  logic                 ss_l_r, ss_l_s;
  logic                 busy_r, busy_s;
  logic                 fin_r, fin_s;
  logic [PAY_WID-1:0]   dout_r, dout_s;
  logic                 err_r, err_s;
  logic [WID-1:0]       word_s;
  logic                 lead_s;
  logic                 shift_now_s;

  assign word_s = cmd_word(op, data_in);

  assign busy     = busy_r;
  assign finished = fin_r;
  assign data_out = dout_r;
  assign rd_err   = err_r;
  assign sck      = sck_r;
  assign mosi     = mosi_r;
  assign ss_L     = ss_l_r;

  // State and output registers; reset forces the bus idle at once.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_r <= IDLE;
      timer_r <= {TIMER_WID{1'b0}};
      edge_r  <= {CNT_WID{1'b0}};
      op_r    <= 2'b00;
      frame_r <= 1'b0;
      tx_r    <= {WID{1'b0}};
      rx_r    <= {WID{1'b0}};
      sck_r   <= SCK_IDLE;
      mosi_r  <= 1'b0;
      ss_l_r  <= 1'b1;
      busy_r  <= 1'b0;
      fin_r   <= 1'b0;
      dout_r  <= {PAY_WID{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
      edge_r  <= edge_s;
      op_r    <= op_s;
      frame_r <= frame_s;
      tx_r    <= tx_s;
      rx_r    <= rx_s;
      sck_r   <= sck_s;
      mosi_r  <= mosi_s;
      ss_l_r  <= ss_l_s;
      busy_r  <= busy_s;
      fin_r   <= fin_s;
      dout_r  <= dout_s;
      err_r   <= err_s;
    end
  end

  // Next-state and next-output logic of the transaction sequencer.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    edge_s  = edge_r;
    op_s    = op_r;
    frame_s = frame_r;
    tx_s    = tx_r;
    rx_s    = rx_r;
    sck_s   = sck_r;
    mosi_s  = mosi_r;
    ss_l_s  = ss_l_r;
    busy_s  = busy_r;
    fin_s   = fin_r;
    dout_s  = dout_r;
    err_s   = err_r;
    // Even edge count = leading edge. PHASE=1 shifts on leading, PHASE=0 on trailing.
    lead_s      = ~edge_r[0];
    shift_now_s = (PHASE != 0) ? lead_s : ~lead_s;

    case (state_r)
      IDLE: begin
        if (arm && !fin_r) begin
          op_s    = op;
          frame_s = 1'b0;
          busy_s  = 1'b1;
          ss_l_s  = 1'b0;
          timer_s = {TIMER_WID{1'b0}};
          state_s = SETUP;
          // PHASE=0 needs the MSB valid before the first (sampling) edge.
          if (PHASE == 0) begin
            mosi_s = word_s[WID-1];
            tx_s   = {word_s[WID-2:0], 1'b0};
          end else begin
            mosi_s = 1'b0;
            tx_s   = word_s;
          end
        end else begin
          state_s = IDLE;
        end
      end

      SETUP: begin
        if (timer_r == SS_LAST) begin
          timer_s = {TIMER_WID{1'b0}};
          edge_s  = {CNT_WID{1'b0}};
          state_s = SHIFT;
        end else begin
          timer_s = timer_r + 1'b1;
        end
      end

      SHIFT: begin
        if (timer_r == HALF_LAST) begin
          timer_s = {TIMER_WID{1'b0}};
          sck_s   = ~sck_r;
          edge_s  = edge_r + 1'b1;
          if (shift_now_s) begin
            mosi_s = tx_r[WID-1];
            tx_s   = {tx_r[WID-2:0], 1'b0};
          end else begin
            rx_s = {rx_r[WID-2:0], miso};
          end
          // 2*WID toggles leave sck back at its idle level.
          if (edge_r == LAST_EDGE) begin
            edge_s  = {CNT_WID{1'b0}};
            state_s = HOLD;
          end else begin
            state_s = SHIFT;
          end
        end else begin
          timer_s = timer_r + 1'b1;
        end
      end

      HOLD: begin
        if (timer_r == SS_LAST) begin
          timer_s = {TIMER_WID{1'b0}};
          ss_l_s  = 1'b1;
          mosi_s  = 1'b0;
          state_s = GAP;
        end else begin
          timer_s = timer_r + 1'b1;
        end
      end

      GAP: begin
        if (timer_r == SS_LAST) begin
          timer_s = {TIMER_WID{1'b0}};
          if (op_r[0] && !frame_r) begin
            // Second frame of a read: a NOP that clocks the response out.
            frame_s = 1'b1;
            ss_l_s  = 1'b0;
            mosi_s  = 1'b0;
            tx_s    = {WID{1'b0}};
            state_s = SETUP;
          end else begin
            busy_s  = 1'b0;
            fin_s   = 1'b1;
            state_s = DONE;
            if (op_r[0]) begin
              err_s = (rx_r[WID-1:WID-4] != op_header(op_r));
              if (op_r[1]) begin
                dout_s = rx_r[PAY_WID-1:0];
              end else begin
                dout_s = rx_r[PAY_WID-1:0] & DAC_MASK;
              end
            end else begin
              err_s = err_r;
            end
          end
        end else begin
          timer_s = timer_r + 1'b1;
        end
      end

      DONE: begin
        if (!arm) begin
          fin_s   = 1'b0;
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end

      default: begin
        state_s = IDLE;
        sck_s   = SCK_IDLE;
        ss_l_s  = 1'b1;
        mosi_s  = 1'b0;
        busy_s  = 1'b0;
        fin_s   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dac_controller.sv
// -----------------------------------------------------------------------------
// tb_dac_controller
//   Bench for dac_controller. It builds four copies, one for each POLARITY/PHASE
//   combination, and drives all four from the same arm/op/data_in stimulus.
//   Each copy has its own behavioural DAC slave. The slave decodes write frames
//   into curset/ctrl and answers read commands in the following frame.
//   A table of directed ops is followed by hand sequences: arm held past
//   completion, arm dropped mid-op, and a reset in the middle of a frame.
// -----------------------------------------------------------------------------
module tb_dac_controller;

  localparam int WID       = 24;
  localparam int PW        = WID - 4;
  localparam int HALF_WAIT = 2;
  localparam int SS_WAIT   = 2;
  localparam int FRAME_CYC = 3 * SS_WAIT + 2 * WID * HALF_WAIT;
  localparam int BUDGET    = 600;

  logic          clk;
  logic          rst_L;
  logic          arm;
  logic [1:0]    op;
  logic [PW-1:0] data_in;
  logic          force_ff;

  logic          busy_a [4];
  logic          fin_a  [4];
  logic          err_a  [4];
  logic          sck_a  [4];
  logic          mosi_a [4];
  logic          ss_a   [4];
  logic [PW-1:0] dout_a [4];
  logic [19:0]   cur_a  [4];
  logic [19:0]   ctl_a  [4];
  int            tog_a  [4];
  int            frm_a  [4];
  int            viol_a [4];

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [1:0]  op;
    logic [19:0] din;
    logic        ff;
    logic [19:0] exp_dout;
    logic        exp_err;
    logic [19:0] exp_cur;
    logic [19:0] exp_ctl;
  } vec_t;

  vec_t vecs [12];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 4; g++) begin : g_combo
    localparam int CPOL = (g / 2) % 2;
    localparam int CPHA = g % 2;

    logic [23:0] sh_in  = 24'h0;
    logic [23:0] sh_out = 24'h0;
    logic [23:0] resp   = 24'h0;
    logic [19:0] curset = 20'h0;
    logic [19:0] ctrl   = 20'h0;
    logic        miso_v = 1'b0;
    int          cnt    = 0;
    int          tog    = 0;
    int          frm    = 0;
    int          viol   = 0;
    time         mch_t  = 0;
    time         samp_t = 0;
    time         chk_t  = 0;

    dac_controller #(
      .POLARITY(CPOL), .PHASE(CPHA), .WID(WID), .DATA_WID(20),
      .HALF_WAIT(HALF_WAIT), .SS_WAIT(SS_WAIT), .TIMER_WID(8)
    ) u_dut (
      .clk(clk), .rst_L(rst_L), .arm(arm), .op(op), .data_in(data_in),
      .busy(busy_a[g]), .finished(fin_a[g]), .data_out(dout_a[g]), .rd_err(err_a[g]),
      .sck(sck_a[g]), .mosi(mosi_a[g]), .miso(miso_v), .ss_L(ss_a[g])
    );

    assign cur_a[g]  = curset;
    assign ctl_a[g]  = ctrl;
    assign tog_a[g]  = tog;
    assign frm_a[g]  = frm;
    assign viol_a[g] = viol;

    // Frame start: load the response; CPHA=0 presents its MSB straight away.
    always @(negedge ss_a[g]) begin
      frm++;
      cnt = 0;
      sh_out = force_ff ? 24'hFFFFFF : resp;
      if (CPHA == 0) begin
        miso_v = sh_out[23];
        sh_out = {sh_out[22:0], 1'b0};
      end
    end

    // Slave shifting: sample on one edge, drive on the other.
    always @(sck_a[g]) begin
      tog++;
      if (ss_a[g] == 1'b0) begin
        if (sck_a[g] == ((CPHA != 0) ? 1'(CPOL) : ~1'(CPOL))) begin
          sh_in  = {sh_in[22:0], mosi_a[g]};
          cnt++;
          samp_t = $time;
        end else begin
          miso_v = sh_out[23];
          sh_out = {sh_out[22:0], 1'b0};
        end
      end
    end

    // Frame end: decode only complete frames.
    always @(posedge ss_a[g]) begin
      if (cnt == 24) begin
        case (sh_in[23:20])
          4'b0001: begin curset = sh_in[19:0]; resp = 24'h0; end
          4'b0010: begin ctrl = sh_in[19:0]; resp = 24'h0; end
          4'b1001: resp = {4'b1001, curset};
          4'b1010: resp = {4'b1010, ctrl};
          default: resp = 24'h0;
        endcase
      end
    end

    always @(mosi_a[g]) mch_t = $time;

    // mosi must never move at the same instant as a sampling edge.
    always @(negedge clk) begin
      if (samp_t != 0 && samp_t == mch_t && samp_t != chk_t) begin
        viol++;
        chk_t = samp_t;
      end
    end
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic wait_fin(output int n);
    n = 0;
    while (n < BUDGET) begin
      @(negedge clk);
      n++;
      if (fin_a[0]) break;
    end
    if (n >= BUDGET) chk("done_timeout", 0, {31'd0, fin_a[0]}, 32'd1);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [19:0] d, output int n);
    int w;
    @(negedge clk);
    op = o;
    data_in = d;
    arm = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk("busy_start", i, {31'd0, busy_a[i]}, 32'd1);
    wait_fin(w);
    n = 1 + w;
  endtask

  task automatic release_arm;
    arm = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk("fin_clear", i, {31'd0, fin_a[i]}, 32'd0);
  endtask

  initial begin
    int n;
    int t0 [4];
    int f0 [4];
    arm = 1'b0;
    op = 2'b00;
    data_in = '0;
    force_ff = 1'b0;
    rst_L = 1'b0;

    vecs[0]  = '{2'd0, 20'h12345, 1'b0, 20'h00000, 1'b0, 20'h12345, 20'h00000};
    vecs[1]  = '{2'd1, 20'h77777, 1'b0, 20'h12345, 1'b0, 20'h12345, 20'h00000};
    vecs[2]  = '{2'd2, 20'hABCDE, 1'b0, 20'h12345, 1'b0, 20'h12345, 20'hABCDE};
    vecs[3]  = '{2'd3, 20'h00000, 1'b0, 20'hABCDE, 1'b0, 20'h12345, 20'hABCDE};
    vecs[4]  = '{2'd0, 20'hFFFFF, 1'b0, 20'hABCDE, 1'b0, 20'hFFFFF, 20'hABCDE};
    vecs[5]  = '{2'd1, 20'h00000, 1'b0, 20'hFFFFF, 1'b0, 20'hFFFFF, 20'hABCDE};
    vecs[6]  = '{2'd0, 20'h00001, 1'b0, 20'hFFFFF, 1'b0, 20'h00001, 20'hABCDE};
    vecs[7]  = '{2'd1, 20'h00000, 1'b1, 20'hFFFFF, 1'b1, 20'h00001, 20'hABCDE};
    vecs[8]  = '{2'd3, 20'h00000, 1'b1, 20'hFFFFF, 1'b1, 20'h00001, 20'hABCDE};
    vecs[9]  = '{2'd1, 20'h00000, 1'b0, 20'h00001, 1'b0, 20'h00001, 20'hABCDE};
    vecs[10] = '{2'd2, 20'h00000, 1'b0, 20'h00001, 1'b0, 20'h00001, 20'h00000};
    vecs[11] = '{2'd3, 20'h55555, 1'b0, 20'h00000, 1'b0, 20'h00001, 20'h00000};

    // Reset state.
    #12;
    for (int i = 0; i < 4; i++) begin
      chk("rst_sck", i, {31'd0, sck_a[i]}, (i / 2) % 2);
      chk("rst_ss", i, {31'd0, ss_a[i]}, 32'd1);
      chk("rst_mosi", i, {31'd0, mosi_a[i]}, 32'd0);
      chk("rst_busy", i, {31'd0, busy_a[i]}, 32'd0);
      chk("rst_fin", i, {31'd0, fin_a[i]}, 32'd0);
      chk("rst_dout", i, {12'd0, dout_a[i]}, 32'd0);
      chk("rst_err", i, {31'd0, err_a[i]}, 32'd0);
    end
    @(negedge clk);
    rst_L = 1'b1;
    repeat (2) @(negedge clk);

    // Directed op table.
    for (int v = 0; v < 12; v++) begin
      force_ff = vecs[v].ff;
      for (int i = 0; i < 4; i++) begin t0[i] = tog_a[i]; f0[i] = frm_a[i]; end
      run_op(vecs[v].op, vecs[v].din, n);
      chk("latency", v, n, vecs[v].op[0] ? 1 + 2 * FRAME_CYC : 1 + FRAME_CYC);
      for (int i = 0; i < 4; i++) begin
        chk("fin", i, {31'd0, fin_a[i]}, 32'd1);
        chk("busy_end", i, {31'd0, busy_a[i]}, 32'd0);
        chk("dout", i, {12'd0, dout_a[i]}, {12'd0, vecs[v].exp_dout});
        chk("rd_err", i, {31'd0, err_a[i]}, {31'd0, vecs[v].exp_err});
        chk("curset", i, {12'd0, cur_a[i]}, {12'd0, vecs[v].exp_cur});
        chk("ctrl", i, {12'd0, ctl_a[i]}, {12'd0, vecs[v].exp_ctl});
        chk("sck_toggles", i, tog_a[i] - t0[i], vecs[v].op[0] ? 4 * WID : 2 * WID);
        chk("ss_windows", i, frm_a[i] - f0[i], vecs[v].op[0] ? 2 : 1);
      end
      release_arm();
    end
    force_ff = 1'b0;

    // Arm held high past completion: no second transaction.
    for (int i = 0; i < 4; i++) f0[i] = frm_a[i];
    run_op(2'd0, 20'h2468A, n);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("hold_fin", i, {31'd0, fin_a[i]}, 32'd1);
      chk("hold_busy", i, {31'd0, busy_a[i]}, 32'd0);
      chk("hold_windows", i, frm_a[i] - f0[i], 32'd1);
      chk("hold_curset", i, {12'd0, cur_a[i]}, 32'h2468A);
    end
    release_arm();

    // Arm dropped mid-op: op still completes, finished lasts one cycle.
    @(negedge clk);
    op = 2'd2;
    data_in = 20'h13579;
    arm = 1'b1;
    repeat (30) @(negedge clk);
    arm = 1'b0;
    wait_fin(n);
    chk("drop_latency", 0, 30 + n, 1 + FRAME_CYC);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("drop_fin_clear", i, {31'd0, fin_a[i]}, 32'd0);
      chk("drop_ctrl", i, {12'd0, ctl_a[i]}, 32'h13579);
    end

    // Reset after 10 bits of a write: frame aborted, curset untouched.
    @(negedge clk);
    op = 2'd0;
    data_in = 20'h55555;
    arm = 1'b1;
    repeat (45) @(negedge clk);
    rst_L = 1'b0;
    arm = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("abort_ss", i, {31'd0, ss_a[i]}, 32'd1);
      chk("abort_sck", i, {31'd0, sck_a[i]}, (i / 2) % 2);
      chk("abort_busy", i, {31'd0, busy_a[i]}, 32'd0);
      chk("abort_fin", i, {31'd0, fin_a[i]}, 32'd0);
    end
    @(negedge clk);
    rst_L = 1'b1;
    for (int i = 0; i < 4; i++) chk("abort_curset", i, {12'd0, cur_a[i]}, 32'h2468A);
    run_op(2'd1, 20'h00000, n);
    for (int i = 0; i < 4; i++) begin
      chk("post_dout", i, {12'd0, dout_a[i]}, 32'h2468A);
      chk("post_err", i, {31'd0, err_a[i]}, 32'd0);
    end
    release_arm();

    for (int i = 0; i < 4; i++) chk("mosi_on_sample_edge", i, viol_a[i], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
